lfa_line_tracker: RTL and testbench

Parametrised line-following controller for the three-sensor LFA front end. It classifies each ADC reading against configurable black/white thresholds and drives both H-bridge direction pins and 4-bit duty commands to the downstream PWM generator. It confirms nodes with a debounce counter, executes a per-node turn command, recovers from line loss, and halts at a programmable stop node.

---
 rtl/lfa_line_tracker.sv | 229 ++++++++++++++++++++++
 tb/tb_lfa_line_tracker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lfa_line_tracker.sv
// Three-sensor line follower: threshold classification, node debounce/turns, line-loss recovery, stop node.
// Optional macro LFA_LOST_RECOVERY_EN: LOST pivots toward the last side seen black instead of stopping.
`timescale 1ns/1ps
module lfa_line_tracker #(
  parameter int unsigned ADC_W        = 12,
  parameter int unsigned HI_TH        = 1000,
  parameter int unsigned LO_TH        = 200,
  parameter int unsigned DUTY_W       = 4,
  parameter int unsigned DUTY_FWD     = 8,
  parameter int unsigned DUTY_HI      = 9,
  parameter int unsigned DUTY_LO      = 3,
  parameter int unsigned DUTY_TURN    = 7,
  parameter int unsigned NODE_W       = 8,
  parameter int unsigned NODE_CONFIRM = 16,
  parameter int unsigned LOST_TIMEOUT = 3125,
  parameter int unsigned STOP_NODE    = 11
) (
  input  logic              clk_3125KHz,
  input  logic              rst,
  input  logic              key,
  input  logic [ADC_W-1:0]  left,
  input  logic [ADC_W-1:0]  middle,
  input  logic [ADC_W-1:0]  right,
  input  logic [1:0]        node_cmd,
  output logic              m1_a,
  output logic              m1_b,
  output logic              m2_a,
  output logic              m2_b,
  output logic [DUTY_W-1:0] dc1,
  output logic [DUTY_W-1:0] dc2,
  output logic [NODE_W-1:0] node,
  output logic              node_flag,
  output logic              node_pulse,
  output logic              running,
  output logic [2:0]        state
);

  localparam int unsigned CNT_W  = $clog2(NODE_CONFIRM + 1);
  localparam int unsigned LOST_W = $clog2(LOST_TIMEOUT + 1);
  localparam int unsigned DRV_W  = 4 + 2 * DUTY_W;

  // Pin order {m1_a, m1_b, m2_a, m2_b}
  localparam logic [3:0] PINS_FWD   = 4'b1010;
  localparam logic [3:0] PINS_PIV_L = 4'b0110;
  localparam logic [3:0] PINS_PIV_R = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FOLLOW    = 3'd1,
    S_NODE      = 3'd2,
    S_TURN_EXIT = 3'd3,
    S_TURN_ACQ  = 3'd4,
    S_LOST      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  function automatic logic [DRV_W-1:0] drv(input logic [3:0] pins, input int unsigned d1,
                                           input int unsigned d2);
    return {pins, DUTY_W'(d1), DUTY_W'(d2)};
  endfunction

  state_t             r_state;
  logic               r_key_s1, r_key_s2;
  logic [DRV_W-1:0]   r_drive;
  logic [CNT_W-1:0]   r_confirm;
  logic [LOST_W-1:0]  r_lost;
  logic [NODE_W-1:0]  r_node;
  logic [1:0]         r_cmd;
  logic               r_node_flag, r_node_pulse, r_running;

  logic w_lb, w_lw, w_mb, w_mw, w_rb, w_rw;
  logic w_amb, w_all_black, w_all_white;
  logic [DRV_W-1:0] w_follow_drv, w_pivot_drv, w_lost_drv;

  assign w_lb = left   > ADC_W'(HI_TH);
  assign w_lw = left   < ADC_W'(LO_TH);
  assign w_mb = middle > ADC_W'(HI_TH);
  assign w_mw = middle < ADC_W'(LO_TH);
  assign w_rb = right  > ADC_W'(HI_TH);
  assign w_rw = right  < ADC_W'(LO_TH);
  assign w_amb       = !(w_lb || w_lw) || !(w_mb || w_mw) || !(w_rb || w_rw);
  assign w_all_black = w_lb && w_mb && w_rb;
  assign w_all_white = w_lw && w_mw && w_rw;

  // Line-following steering; anything unrecognised holds the last command
  always_comb begin
    w_follow_drv = r_drive;
    if (!w_amb) begin
      if (w_mb && w_lw && w_rw)  w_follow_drv = drv(PINS_FWD, DUTY_FWD, DUTY_FWD);
      else if (w_rb && w_lw)     w_follow_drv = drv(PINS_FWD, DUTY_HI, DUTY_LO);
      else if (w_lb && w_rw)     w_follow_drv = drv(PINS_FWD, DUTY_LO, DUTY_HI);
    end
  end

  assign w_pivot_drv = (r_cmd == 2'b01) ? drv(PINS_PIV_L, DUTY_TURN, DUTY_TURN)
                                        : drv(PINS_PIV_R, DUTY_TURN, DUTY_TURN);

`ifdef LFA_LOST_RECOVERY_EN
  localparam logic [1:0] SIDE_NONE  = 2'd0;
  localparam logic [1:0] SIDE_LEFT  = 2'd1;
  localparam logic [1:0] SIDE_RIGHT = 2'd2;
  logic [1:0] r_last_side;

  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      r_last_side <= SIDE_NONE;
    end else if (r_state == S_FOLLOW && !w_amb) begin
      if (w_rb && w_lw)      r_last_side <= SIDE_RIGHT;
      else if (w_lb && w_rw) r_last_side <= SIDE_LEFT;
    end
  end

  // Unrecorded side defaults to a right pivot
  assign w_lost_drv = (r_last_side == SIDE_LEFT) ? drv(PINS_PIV_L, DUTY_TURN, DUTY_TURN)
                                                 : drv(PINS_PIV_R, DUTY_TURN, DUTY_TURN);
`else
  assign w_lost_drv = '0;
`endif

  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
    end else begin
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
    end
  end

  // Main controller FSM with registered outputs
  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_drive      <= '0;
      r_confirm    <= '0;
      r_lost       <= '0;
      r_node       <= '0;
      r_cmd        <= '0;
      r_node_flag  <= 1'b0;
      r_node_pulse <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_node_pulse <= 1'b0;
      r_node_flag  <= w_all_black;
      case (r_state)
        S_IDLE: begin
          r_drive <= '0;
          if (!r_key_s2) begin
            r_state   <= S_FOLLOW;
            r_running <= 1'b1;
            r_drive   <= w_follow_drv;
          end
        end
        S_FOLLOW: begin
          r_drive <= w_follow_drv;
          if (w_all_black) begin
            if (r_confirm >= CNT_W'(NODE_CONFIRM - 1)) begin
              r_confirm    <= CNT_W'(NODE_CONFIRM);
              r_node       <= r_node + NODE_W'(1);
              r_node_pulse <= 1'b1;
              r_cmd        <= node_cmd;
              r_state      <= S_NODE;
            end else begin
              r_confirm <= r_confirm + CNT_W'(1);
            end
          end else begin
            r_confirm <= '0;
          end
          if (w_all_white) begin
            if (r_lost >= LOST_W'(LOST_TIMEOUT - 1)) begin
              r_lost  <= LOST_W'(LOST_TIMEOUT);
              r_state <= S_LOST;
              r_drive <= w_lost_drv;
            end else begin
              r_lost <= r_lost + LOST_W'(1);
            end
          end else begin
            r_lost <= '0;
          end
        end
        S_NODE: begin
          r_confirm <= '0;
          if (r_node == NODE_W'(STOP_NODE) || r_cmd == 2'b11) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_drive   <= '0;
          end else if (r_cmd == 2'b00) begin
            r_drive <= drv(PINS_FWD, DUTY_FWD, DUTY_FWD);
            if (!w_all_black) r_state <= S_FOLLOW;
          end else begin
            r_drive <= w_pivot_drv;
            r_state <= S_TURN_EXIT;
          end
        end
        S_TURN_EXIT: begin
          r_drive <= w_pivot_drv;
          if (w_mw) r_state <= S_TURN_ACQ;
        end
        S_TURN_ACQ: begin
          r_drive <= w_pivot_drv;
          if (w_mb) r_state <= S_FOLLOW;
        end
        S_LOST: begin
          r_drive <= w_lost_drv;
          if (w_mb) begin
            r_lost  <= '0;
            r_state <= S_FOLLOW;
          end
        end
        S_DONE: begin
          r_drive <= '0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_drive   <= '0;
        end
      endcase
    end
  end

  assign {m1_a, m1_b, m2_a, m2_b, dc1, dc2} = r_drive;
  assign node       = r_node;
  assign node_flag  = r_node_flag;
  assign node_pulse = r_node_pulse;
  assign running    = r_running;
  assign state      = r_state;

endmodule

// File: tb/tb_lfa_line_tracker.sv
// Directed bench for lfa_line_tracker: steering vector table plus node, turn, lost, stop and reset sequences.
`timescale 1ns/1ps
module tb_lfa_line_tracker;

  localparam int unsigned ADC_W  = 12;
  localparam int unsigned DUTY_W = 4;
  localparam int unsigned NODE_W = 8;

  logic              clk;
  logic              rst;
  logic              key;
  logic [ADC_W-1:0]  left, middle, right;
  logic [1:0]        node_cmd;
  logic              m1_a, m1_b, m2_a, m2_b;
  logic [DUTY_W-1:0] dc1, dc2;
  logic [NODE_W-1:0] node;
  logic              node_flag, node_pulse, running;
  logic [2:0]        state;

  lfa_line_tracker dut (
    .clk_3125KHz(clk), .rst(rst), .key(key),
    .left(left), .middle(middle), .right(right), .node_cmd(node_cmd),
    .m1_a(m1_a), .m1_b(m1_b), .m2_a(m2_a), .m2_b(m2_b),
    .dc1(dc1), .dc2(dc2), .node(node), .node_flag(node_flag),
    .node_pulse(node_pulse), .running(running), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int l;
    int m;
    int r;
    int d1;
    int d2;
  } vec_t;

  vec_t vecs[10];
  int   n_pass  = 0;
  int   n_total = 0;
  int   pulses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_s(input int l, input int m, input int r);
    left   = ADC_W'(l);
    middle = ADC_W'(m);
    right  = ADC_W'(r);
  endtask

  function automatic logic [31:0] drv_now();
    return 32'({m1_a, m1_b, m2_a, m2_b, dc1, dc2});
  endfunction

  function automatic logic [31:0] drv_exp(input logic [3:0] pins, input int d1, input int d2);
    return 32'({pins, DUTY_W'(d1), DUTY_W'(d2)});
  endfunction

  function automatic logic [31:0] all_now();
    return 32'({state, node, node_flag, node_pulse, running, m1_a, m1_b, m2_a, m2_b, dc1, dc2});
  endfunction

  initial begin
    vecs[0] = '{l: 100,  m: 3000, r: 100,  d1: 8, d2: 8};
    vecs[1] = '{l: 100,  m: 3000, r: 3000, d1: 9, d2: 3};
    vecs[2] = '{l: 100,  m: 1000, r: 100,  d1: 9, d2: 3};
    vecs[3] = '{l: 100,  m: 1001, r: 100,  d1: 8, d2: 8};
    vecs[4] = '{l: 3000, m: 3000, r: 100,  d1: 3, d2: 9};
    vecs[5] = '{l: 3000, m: 100,  r: 3000, d1: 3, d2: 9};
    vecs[6] = '{l: 199,  m: 3000, r: 200,  d1: 3, d2: 9};
    vecs[7] = '{l: 199,  m: 3000, r: 199,  d1: 8, d2: 8};
    vecs[8] = '{l: 100,  m: 100,  r: 3000, d1: 9, d2: 3};
    vecs[9] = '{l: 100,  m: 3000, r: 100,  d1: 8, d2: 8};

    rst = 1'b1;
    key = 1'b1;
    node_cmd = 2'b00;
    set_s(3000, 3000, 3000);
    @(negedge clk);
    @(negedge clk);
    check("reset_all_zero", all_now(), 32'd0);
    rst = 1'b0;
    repeat (5) step();
    check("idle_state", 32'(state), 32'd0);
    check("idle_motors", drv_now(), 32'd0);
    check("idle_node", 32'(node), 32'd0);
    check("idle_flag_running", 32'({node_flag, running}), 32'b10);

    key = 1'b0;
    set_s(100, 3000, 100);
    repeat (3) step();
    key = 1'b1;
    check("start_state", 32'({state, running}), 32'({3'd1, 1'b1}));
    check("start_motors", drv_now(), drv_exp(4'b1010, 8, 8));

    for (int i = 0; i < 10; i++) begin
      set_s(vecs[i].l, vecs[i].m, vecs[i].r);
      step();
      check($sformatf("vec%0d_drive", i), drv_now(), drv_exp(4'b1010, vecs[i].d1, vecs[i].d2));
      check($sformatf("vec%0d_state", i), 32'(state), 32'd1);
    end

    pulses = 0;
    set_s(3000, 3000, 3000);
    for (int i = 0; i < 15; i++) begin
      step();
      if (node_pulse) pulses++;
    end
    set_s(100, 3000, 100);
    step();
    if (node_pulse) pulses++;
    check("confirm15_no_pulse", 32'({pulses[7:0], node}), 32'd0);
    check("confirm15_flag_clear", 32'({node_flag, state}), 32'd1);

    pulses = 0;
    set_s(3000, 3000, 3000);
    for (int i = 0; i < 16; i++) begin
      node_cmd = (i == 15) ? 2'b01 : 2'b10;
      step();
      if (node_pulse) pulses++;
    end
    check("confirm16_pulse_count", 32'(pulses), 32'd1);
    check("confirm16_out", 32'({node_pulse, node_flag, node, state}), 32'({1'b1, 1'b1, 8'd1, 3'd2}));
    check("node_hold_cmd", drv_now(), drv_exp(4'b1010, 8, 8));

    node_cmd = 2'b10;
    step();
    check("turn_exit_state", 32'({node_pulse, state}), 32'({1'b0, 3'd3}));
    check("turn_exit_pivot_left", drv_now(), drv_exp(4'b0110, 7, 7));
    set_s(100, 100, 100);
    step();
    check("turn_acq_state", 32'(state), 32'd4);
    check("turn_acq_pivot", drv_now(), drv_exp(4'b0110, 7, 7));
    set_s(100, 3000, 100);
    step();
    check("turn_to_follow", 32'(state), 32'd1);
    step();
    check("follow_after_turn", drv_now(), drv_exp(4'b1010, 8, 8));

    set_s(50, 50, 50);
    repeat (3124) step();
    check("lost_not_yet", 32'(state), 32'd1);
    step();
    check("lost_state", 32'({state, running}), 32'({3'd5, 1'b1}));
`ifdef LFA_LOST_RECOVERY_EN
    check("lost_pivot_right", drv_now(), drv_exp(4'b1001, 7, 7));
`else
    check("lost_stopped", drv_now(), 32'd0);
`endif
    set_s(100, 3000, 100);
    step();
    check("lost_recover", 32'(state), 32'd1);

    node_cmd = 2'b00;
    for (int n = 2; n <= 10; n++) begin
      set_s(3000, 3000, 3000);
      repeat (16) step();
      set_s(100, 3000, 100);
      step();
    end
    check("straight_nodes", 32'({node, state}), 32'({8'd10, 3'd1}));
    check("straight_drive", drv_now(), drv_exp(4'b1010, 8, 8));
    set_s(3000, 3000, 3000);
    repeat (16) step();
    check("node11_confirm", 32'({node, state}), 32'({8'd11, 3'd2}));
    step();
    check("done_state", 32'({state, running, node}), 32'({3'd6, 1'b0, 8'd11}));
    check("done_motors", drv_now(), 32'd0);
    key = 1'b0;
    set_s(100, 3000, 100);
    repeat (6) step();
    key = 1'b1;
    check("done_sticky", 32'({state, node}), 32'({3'd6, 8'd11}));
    check("done_sticky_motors", drv_now(), 32'd0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    key = 1'b0;
    set_s(100, 3000, 100);
    repeat (3) step();
    key = 1'b1;
    set_s(3000, 3000, 3000);
    for (int i = 0; i < 16; i++) begin
      node_cmd = (i == 15) ? 2'b10 : 2'b01;
      step();
    end
    step();
    check("rerun_turn_exit", 32'({node, state}), 32'({8'd1, 3'd3}));
    check("rerun_pivot_right", drv_now(), drv_exp(4'b1001, 7, 7));
    #2 rst = 1'b1;
    #1 check("rst_mid_turn", all_now(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
